// File: rtl/xps2tx_if.sv
// Bus-side interface of the PS/2 transmitter.
//   sel      : select from the address decoder
//   we       : write enable
//   data_in  : byte to send to the device
//   data_out : status {timeout_err, nack_err, done, busy}
interface xps2tx_if;
  logic       sel;
  logic       we;
  logic [7:0] data_in;
  logic [3:0] data_out;

  modport master (output sel, output we, output data_in, input data_out);
  modport slave  (input sel, input we, input data_in, output data_out);
endinterface

// File: rtl/xps2tx.sv
// PS/2 host-to-device transmitter.
// Sends one command byte per bus write over the open-collector PS/2 lines.
// Ports:
//   clk, rst       : system clock, synchronous active-high reset
//   bus            : bus slave (sel, we, data_in, data_out status)
//   ps2_clk_in     : raw PS/2 clock line level
//   ps2_data_in    : raw PS/2 data line level
//   ps2_clk_oe     : 1 = pull PS/2 clock low
//   ps2_data_oe    : 1 = pull PS/2 data low
//   tx_active      : high while a frame is in progress
//
// state     | meaning
// IDLE      | lines released, waiting for a write
// INHIBIT   | clock held low to request to send; data pulled low on last cycle
// REQ       | start bit on the line, waiting for first device clock
// DATA      | shifting D0..D7 out LSB-first on device falling edges
// PARITY    | parity bit on the line
// ACK       | stop bit (released) on the line, waiting for device ack
// WAIT_IDLE | waiting for both lines high before reporting done
module xps2tx #(
  parameter int INHIBIT_CYCLES = 5000,
  parameter int TIMEOUT_CYCLES = 750000
) (
  input  logic     clk,
  input  logic     rst,
  xps2tx_if.slave  bus,
  input  logic     ps2_clk_in,
  input  logic     ps2_data_in,
  output logic     ps2_clk_oe,
  output logic     ps2_data_oe,
  output logic     tx_active
);

  localparam int IW = (INHIBIT_CYCLES > 1) ? $clog2(INHIBIT_CYCLES) : 1;
  localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [IW-1:0] INH_LOAD = IW'(INHIBIT_CYCLES - 1);
  localparam logic [TW-1:0] TO_LOAD  = TW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_INHIBIT, S_REQ, S_DATA, S_PARITY, S_ACK, S_WAIT_IDLE
  } state_t;

  state_t        state, state_nxt;
  logic [1:0]    clk_sync, data_sync;
  logic          clk_prev;
  logic [8:0]    shreg;
  logic [3:0]    bit_cnt;
  logic [IW-1:0] inh_cnt;
  logic [TW-1:0] to_cnt;
  logic          data_oe_r;
  logic          done, nack_err, timeout_err;

  logic clk_s, data_s, fall, start, active, tmo;

  assign clk_s  = clk_sync[1];
  assign data_s = data_sync[1];
  assign fall   = clk_prev & ~clk_s;
  assign start  = bus.sel & bus.we & (state == S_IDLE);
  assign active = (state == S_REQ) || (state == S_DATA) || (state == S_PARITY) ||
                  (state == S_ACK) || (state == S_WAIT_IDLE);
  // Timeout wins over any edge arriving in the same cycle.
  assign tmo    = active && (to_cnt == '0);

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:      if (start) state_nxt = S_INHIBIT;
      S_INHIBIT:   if (inh_cnt == '0) state_nxt = S_REQ;
      S_REQ:       if (fall) state_nxt = S_DATA;
      S_DATA:      if (fall && bit_cnt == 4'd8) state_nxt = S_PARITY;
      S_PARITY:    if (fall) state_nxt = S_ACK;
      S_ACK:       if (fall) state_nxt = S_WAIT_IDLE;
      S_WAIT_IDLE: if (clk_s && data_s) state_nxt = S_IDLE;
      default:     state_nxt = S_IDLE;
    endcase
    if (tmo) state_nxt = S_IDLE;
  end

  always_comb begin
    tx_active    = (state != S_IDLE);
    ps2_clk_oe   = (state == S_INHIBIT);
    // Start bit goes out on the last inhibit cycle, then is held by data_oe_r.
    ps2_data_oe  = (state == S_INHIBIT) ? (inh_cnt == '0) : data_oe_r;
    bus.data_out = {timeout_err, nack_err, done, tx_active};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      clk_sync    <= 2'b11;
      data_sync   <= 2'b11;
      clk_prev    <= 1'b1;
      shreg       <= '0;
      bit_cnt     <= '0;
      inh_cnt     <= '0;
      to_cnt      <= '0;
      data_oe_r   <= 1'b0;
      done        <= 1'b0;
      nack_err    <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      clk_sync  <= {clk_sync[0], ps2_clk_in};
      data_sync <= {data_sync[0], ps2_data_in};
      clk_prev  <= clk_s;
      if (tmo) begin
        data_oe_r   <= 1'b0;
        timeout_err <= 1'b1;
        done        <= 1'b1;
      end else begin
        if (active) to_cnt <= to_cnt - 1'b1;
        case (state)
          S_IDLE: if (start) begin
            shreg       <= {~^bus.data_in, bus.data_in};
            inh_cnt     <= INH_LOAD;
            data_oe_r   <= 1'b0;
            done        <= 1'b0;
            nack_err    <= 1'b0;
            timeout_err <= 1'b0;
          end
          S_INHIBIT: begin
            if (inh_cnt == '0) begin
              data_oe_r <= 1'b1;
              to_cnt    <= TO_LOAD;
            end else begin
              inh_cnt <= inh_cnt - 1'b1;
            end
          end
          S_REQ: if (fall) begin
            data_oe_r <= ~shreg[0];
            bit_cnt   <= 4'd1;
          end
          // bit_cnt 8 selects the parity bit held above the data byte.
          S_DATA: if (fall) begin
            data_oe_r <= ~shreg[bit_cnt];
            bit_cnt   <= bit_cnt + 4'd1;
          end
          S_PARITY:    if (fall) data_oe_r <= 1'b0;
          S_ACK:       if (fall) nack_err <= data_s;
          S_WAIT_IDLE: if (clk_s && data_s) done <= 1'b1;
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_xps2tx.sv
// Self-checking bench for xps2tx: a PS/2 device model clocks frames out of
// the transmitter and a reference frame model predicts bits and status.
module tb_xps2tx;
  localparam int INH = 300;
  localparam int TMO = 3000;
  localparam int HP  = 12;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  xps2tx_if bus ();
  logic ps2_clk_oe, ps2_data_oe, tx_active;
  logic dev_clk_low = 1'b0, dev_data_low = 1'b0;
  logic ps2_clk_in, ps2_data_in;

  // Open-collector lines with pull-ups.
  assign ps2_clk_in  = ~(ps2_clk_oe | dev_clk_low);
  assign ps2_data_in = ~(ps2_data_oe | dev_data_low);

  xps2tx #(.INHIBIT_CYCLES(INH), .TIMEOUT_CYCLES(TMO)) dut (
    .clk(clk), .rst(rst), .bus(bus),
    .ps2_clk_in(ps2_clk_in), .ps2_data_in(ps2_data_in),
    .ps2_clk_oe(ps2_clk_oe), .ps2_data_oe(ps2_data_oe), .tx_active(tx_active)
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0, failures = 0;
  int rel_cyc = 0;
  logic [10:0] seen;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Odd parity: parity bit set when the byte has an even number of ones.
  function automatic logic odd_par(input logic [7:0] b);
    int n = 0;
    for (int i = 0; i < 8; i++) n += int'(b[i]);
    return (n % 2) == 0;
  endfunction

  function automatic logic [10:0] frame_bits(input logic [7:0] b);
    return {1'b1, odd_par(b), b, 1'b0};
  endfunction

  task automatic write_byte(input logic [7:0] b);
    @(negedge clk);
    bus.sel = 1'b1; bus.we = 1'b1; bus.data_in = b;
    @(negedge clk);
    bus.sel = 1'b0; bus.we = 1'b0;
  endtask

  task automatic check_inhibit(input string tag);
    int n = 0, nd = 0;
    logic last_d = 1'b0;
    while (ps2_clk_oe && n < INH + 50) begin
      n++;
      nd += int'(ps2_data_oe);
      last_d = ps2_data_oe;
      @(negedge clk);
    end
    rel_cyc = cyc;
    check({tag, ".inh_len"}, n, INH);
    check({tag, ".start_cnt"}, nd, 1);
    check({tag, ".start_last"}, last_d, 1'b1);
    check({tag, ".start_held"}, ps2_data_oe, 1'b1);
  endtask

  task automatic dev_clocks(input int first, input int last, input bit ack);
    if (first == 1) begin
      repeat (5) @(negedge clk);
      seen[0] = ps2_data_in;
    end
    for (int k = first; k <= last; k++) begin
      dev_clk_low = 1'b1;
      repeat (HP) @(negedge clk);
      if (k <= 10) seen[k] = ps2_data_in;
      dev_clk_low = 1'b0;
      repeat (HP) @(negedge clk);
      if (k == 10 && ack) dev_data_low = 1'b1;
      if (k == 11) dev_data_low = 1'b0;
    end
  endtask

  task automatic wait_done();
    int n = 0;
    while (!bus.data_out[1] && n < 200) begin
      @(negedge clk);
      n++;
    end
  endtask

  task automatic finish_frame(input logic [7:0] b, input bit ack, input string tag);
    check({tag, ".bits"}, seen, frame_bits(b));
    check({tag, ".parity"}, seen[9], odd_par(b));
    wait_done();
    check({tag, ".status"}, bus.data_out, ack ? 4'b0010 : 4'b0110);
    check({tag, ".lines"}, {ps2_clk_oe, ps2_data_oe, tx_active}, 3'b000);
  endtask

  task automatic frame(input logic [7:0] b, input bit ack, input string tag);
    write_byte(b);
    check({tag, ".busy"}, bus.data_out, 4'b0001);
    check_inhibit(tag);
    dev_clocks(1, 11, ack);
    finish_frame(b, ack, tag);
  endtask

  initial begin
    int n;
    logic [7:0] rb;
    bit rack;
    bus.sel = 1'b0; bus.we = 1'b0; bus.data_in = 8'h00;
    repeat (3) @(negedge clk);
    check("reset.status", bus.data_out, 4'b0000);
    check("reset.lines", {ps2_clk_oe, ps2_data_oe, tx_active}, 3'b000);
    rst = 1'b0;
    repeat (3) @(negedge clk);

    frame(8'hED, 1'b1, "ed");
    check("ed.expected_bits", seen, 11'b11_1110_1101_0);
    frame(8'h07, 1'b1, "x07");

    // Write while busy is ignored; write after done starts a fresh frame.
    write_byte(8'h96);
    check_inhibit("mid");
    dev_clocks(1, 3, 1'b1);
    write_byte(8'h55);
    check("mid.ignored", bus.data_out, 4'b0001);
    dev_clocks(4, 11, 1'b1);
    finish_frame(8'h96, 1'b1, "mid");
    write_byte(8'h00);
    check("redo.cleared", bus.data_out, 4'b0001);
    check_inhibit("x00");
    dev_clocks(1, 11, 1'b1);
    finish_frame(8'h00, 1'b1, "x00");

    frame(8'h3C, 1'b0, "nack");

    // No device clocks at all.
    write_byte(8'h5A);
    check_inhibit("tmo");
    n = 0;
    while (!bus.data_out[3] && n < TMO + 100) begin
      @(negedge clk);
      n++;
    end
    check("tmo.cycles", cyc - rel_cyc, TMO);
    check("tmo.status", bus.data_out, 4'b1010);
    check("tmo.lines", {ps2_clk_oe, ps2_data_oe}, 2'b00);

    // Reset in the middle of the data bits.
    write_byte(8'hA3);
    check_inhibit("rst");
    dev_clocks(1, 4, 1'b1);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("rst.lines", {ps2_clk_oe, ps2_data_oe, tx_active}, 3'b000);
    check("rst.status", bus.data_out, 4'b0000);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    frame(8'hFF, 1'b1, "after_rst");

    for (int i = 0; i < 6; i++) begin
      rb   = 8'($urandom_range(0, 255));
      rack = ($urandom_range(0, 3) != 0);
      frame(rb, rack, $sformatf("rnd%0d_%02h", i, rb));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
